// File: rtl/pu_msp430_wakeup_pkg.sv
// Shared types and helpers for the MSP430 wakeup sequencer.
//   wkup_state_e : sequencer states (IDLE, REQ, CLEAR, RELEASE)
//   NSRC_MAX     : largest supported number of wakeup sources
//   IDX_W        : index width able to address NSRC_MAX sources
//   CNT_W        : width of the clear-timeout counter
//   rr_pick()    : round-robin winner search over a pending vector
package pu_msp430_wakeup_pkg;

    localparam int unsigned NSRC_MAX = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CLEAR   = 2'd2,
        RELEASE = 2'd3
    } wkup_state_e;

    // Searches pend starting at (last_id+1) and wrapping at nsrc. The wrap is
    // an explicit compare so non power-of-two source counts work. Returns
    // last_id when nothing is pending; callers only use the result when
    // something is pending.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NSRC_MAX-1:0] pend,
        input logic [IDX_W-1:0]    last_id,
        input int unsigned         nsrc
    );
        logic [IDX_W-1:0] pick;
        logic             found;
        int unsigned      cand;
        pick  = last_id;
        found = 1'b0;
        for (int unsigned i = 1; i <= NSRC_MAX; i++) begin
            cand = 32'(last_id) + i;
            if (cand >= nsrc) begin
                cand = cand - nsrc;
            end
            if (!found && (i <= nsrc) && pend[cand[IDX_W-1:0]]) begin
                pick  = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/pu_msp430_sync_cell.sv
// Two-flop synchronizer bringing asynchronous levels into the clk domain.
//   clk        : destination clock
//   rst        : asynchronous active-high reset, clears both stages
//   data_async : asynchronous input level(s)
//   data_sync  : synchronized output, two clk edges behind data_async
module pu_msp430_sync_cell #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_async,
    output logic [WIDTH-1:0] data_sync
);

    logic [WIDTH-1:0] meta_q;

    // First stage may go metastable; second stage is the only one consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q    <= '0;
            data_sync <= '0;
        end else begin
            meta_q    <= data_async;
            data_sync <= meta_q;
        end
    end

endmodule

// File: rtl/pu_msp430_wakeup_ctrl.sv
// Wakeup sequencer for a bank of NSRC asynchronous wakeup capture cells.
// Synchronizes each sticky wakeup flag, picks one pending source round-robin,
// requests service from the CPU, and after acknowledge holds the cell's clear
// until its flag is seen low (or a timeout expires), then rearms.
//
// Build option: define WKUP_MASK_EN to add the wkup_mask_i per-source enable.
//
// Ports:
//   mclk         : main clock
//   puc_rst      : asynchronous active-high reset
//   wkup_flag_i  : raw asynchronous wkup_out of each cell
//   wkup_mask_i  : per-source enable, 1=enabled (WKUP_MASK_EN only)
//   wkup_req_o   : wakeup request level, held until acknowledge
//   wkup_id_o    : index of the source being serviced
//   wkup_ack_i   : CPU acknowledge, only honoured while wkup_req_o=1
//   wkup_clear_o : registered one-hot clear toward the cells
//   wkup_pend_o  : synchronized, masked pending vector
//   wkup_err_o   : sticky clear-timeout error
//   err_clr_i    : clears wkup_err_o (a new timeout wins)
module pu_msp430_wakeup_ctrl
    import pu_msp430_wakeup_pkg::*;
#(
    parameter int unsigned NSRC        = 4,
    parameter int unsigned CLR_TIMEOUT = 15,
    localparam int unsigned IDW        = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic            mclk,
    input  logic            puc_rst,
    input  logic [NSRC-1:0] wkup_flag_i,
`ifdef WKUP_MASK_EN
    input  logic [NSRC-1:0] wkup_mask_i,
`endif
    output logic            wkup_req_o,
    output logic [IDW-1:0]  wkup_id_o,
    input  logic            wkup_ack_i,
    output logic [NSRC-1:0] wkup_clear_o,
    output logic [NSRC-1:0] wkup_pend_o,
    output logic            wkup_err_o,
    input  logic            err_clr_i
);

    wkup_state_e      state_q, state_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   last_id_q, last_id_d;
    logic             req_q, req_d;
    logic [NSRC-1:0]  clear_q, clear_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             err_set;

    logic [NSRC-1:0]  sync_q;
    logic [NSRC-1:0]  mask_c;
    logic [NSRC-1:0]  pend_c;
    logic [IDW-1:0]   pick_c;

    // One synchronizer per source so each flag is resolved independently.
    for (genvar g = 0; g < NSRC; g++) begin : g_sync
        pu_msp430_sync_cell #(
            .WIDTH(1)
        ) u_sync (
            .clk        (mclk),
            .rst        (puc_rst),
            .data_async (wkup_flag_i[g]),
            .data_sync  (sync_q[g])
        );
    end

`ifdef WKUP_MASK_EN
    assign mask_c = wkup_mask_i;
`else
    assign mask_c = '1;
`endif

    // Masking only gates arbitration and visibility; sync flops keep running.
    assign pend_c      = sync_q & mask_c;
    assign wkup_pend_o = pend_c;

    assign pick_c = IDW'(rr_pick(NSRC_MAX'(pend_c), IDX_W'(last_id_q), NSRC));

    // State and registered outputs.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q   <= IDLE;
            id_q      <= '0;
            last_id_q <= IDW'(NSRC - 1);
            req_q     <= 1'b0;
            clear_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            req_q     <= req_d;
            clear_q   <= clear_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        req_d     = req_q;
        clear_d   = clear_q;
        cnt_d     = cnt_q;
        err_set   = 1'b0;

        case (state_q)
            IDLE: begin
                if (|pend_c) begin
                    id_d      = pick_c;
                    last_id_d = pick_c;
                    req_d     = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // Once latched, the transfer completes even if the source is
                // masked or its flag falls.
                if (wkup_ack_i) begin
                    req_d   = 1'b0;
                    clear_d = NSRC'(1) << id_q;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Completion looks at the unmasked flag: the cell itself.
                if (!sync_q[id_q]) begin
                    clear_d = '0;
                    state_d = RELEASE;
                end else if (cnt_q == CNT_W'(CLR_TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    clear_d = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Guarantees a clear-low cycle before the cell can be cleared again.
                state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                clear_d = '0;
                state_d = IDLE;
            end
        endcase

        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign wkup_req_o   = req_q;
    assign wkup_id_o    = id_q;
    assign wkup_clear_o = clear_q;
    assign wkup_err_o   = err_q;

endmodule
